// File: rtl/memory_rdata_demux_pkg.sv
// Types and helpers for the memory read-return path. Shared by the tag
// pipeline and by the return demultiplexer.
package memory_pkg;

  localparam int unsigned MAX_PORTS = 16;

  typedef logic [3:0] port_idx_t;

  typedef struct packed {
    logic      valid;
    port_idx_t idx;
  } rtag_t;

  function automatic port_idx_t lowest_set_index(input logic [MAX_PORTS-1:0] vec);
    port_idx_t idx;
    logic      found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      if (vec[i] && !found) begin
        idx   = port_idx_t'(i);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/memory_rdata_demux_rtag_pipe.sv
// Fixed-depth shift register of read tags. It never stalls and clears
// synchronously on an active-low reset.
module rtag_pipe
  import memory_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  rtag_t tag_in,
  output rtag_t tag_out,
  output logic  any_valid
);

  rtag_t stage_q [Depth];
  rtag_t stage_d [Depth];

  always_comb begin
    stage_d[0] = tag_in;
    for (int unsigned i = 1; i < Depth; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < Depth; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < Depth; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign tag_out = stage_q[Depth-1];

endmodule

// File: rtl/memory_rdata_demux.sv
// Routes fixed-latency memory read data back to the requester that issued
// each read. Each output is a packed {valid, data} bundle.
module memory_rdata_demux
  import memory_pkg::*;
#(
  parameter int unsigned ParamNumPorts    = 1,
  parameter int unsigned DataWidth        = 32,
  parameter int unsigned ParamReadLatency = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          rd_req,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic [DataWidth:0]   output0,
  output logic [DataWidth:0]   output1,
  output logic [DataWidth:0]   output2,
  output logic [DataWidth:0]   output3,
  output logic [DataWidth:0]   output4,
  output logic [DataWidth:0]   output5,
  output logic [DataWidth:0]   output6,
  output logic [DataWidth:0]   output7,
  output logic [DataWidth:0]   output8,
  output logic [DataWidth:0]   output9,
  output logic [DataWidth:0]   output10,
  output logic [DataWidth:0]   output11,
  output logic [DataWidth:0]   output12,
  output logic [DataWidth:0]   output13,
  output logic [DataWidth:0]   output14,
  output logic [DataWidth:0]   output15,
  output logic                 busy,
  output logic                 collision
);

  logic [MAX_PORTS-1:0] port_mask;
  logic [MAX_PORTS-1:0] req_m;
  rtag_t                issue_tag;
  rtag_t                ret_tag;

  logic                 collision_q, collision_d;
  logic [MAX_PORTS-1:0] rtn_valid_q, rtn_valid_d;
  logic [DataWidth-1:0] rtn_data_q [MAX_PORTS];
  logic [DataWidth-1:0] rtn_data_d [MAX_PORTS];
  logic [DataWidth:0]   out_bus    [MAX_PORTS];

  always_comb begin
    port_mask = '0;
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      port_mask[i] = (i < ParamNumPorts);
    end
  end

  assign req_m           = rd_req & port_mask;
  assign issue_tag.valid = |req_m;
  assign issue_tag.idx   = lowest_set_index(req_m);

  rtag_pipe #(
    .Depth(ParamReadLatency)
  ) u_rtag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .tag_in   (issue_tag),
    .tag_out  (ret_tag),
    .any_valid(busy)
  );

  // Clearing the lowest set bit leaves a nonzero value only for multi-hot requests.
  assign collision_d = collision_q | ((req_m & (req_m - 16'd1)) != '0);

  always_comb begin
    rtn_valid_d = '0;
    rtn_data_d  = rtn_data_q;
    if (ret_tag.valid) begin
      rtn_valid_d[ret_tag.idx] = 1'b1;
      rtn_data_d[ret_tag.idx]  = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision_q <= 1'b0;
      rtn_valid_q <= '0;
      for (int unsigned i = 0; i < MAX_PORTS; i++) begin
        rtn_data_q[i] <= '0;
      end
    end else begin
      collision_q <= collision_d;
      rtn_valid_q <= rtn_valid_d;
      for (int unsigned i = 0; i < MAX_PORTS; i++) begin
        rtn_data_q[i] <= rtn_data_d[i];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < MAX_PORTS; i++) begin
      out_bus[i] = port_mask[i] ? {rtn_valid_q[i], rtn_data_q[i]} : '0;
    end
  end

  assign collision = collision_q;
  assign output0   = out_bus[0];
  assign output1   = out_bus[1];
  assign output2   = out_bus[2];
  assign output3   = out_bus[3];
  assign output4   = out_bus[4];
  assign output5   = out_bus[5];
  assign output6   = out_bus[6];
  assign output7   = out_bus[7];
  assign output8   = out_bus[8];
  assign output9   = out_bus[9];
  assign output10  = out_bus[10];
  assign output11  = out_bus[11];
  assign output12  = out_bus[12];
  assign output13  = out_bus[13];
  assign output14  = out_bus[14];
  assign output15  = out_bus[15];

endmodule

// File: tb/tb_memory_rdata_demux.sv
// Directed bench: three DUT configurations share one stimulus bus; each
// section checks the instance whose parameters it targets.
module tb_memory_rdata_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] rd_req;
  logic [31:0] mem_rdata;

  logic [32:0] oa [16];
  logic [32:0] ob [16];
  logic [32:0] oc [16];
  logic busy_a, busy_b, busy_c, coll_a, coll_b, coll_c;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  memory_rdata_demux #(.ParamNumPorts(16), .DataWidth(32), .ParamReadLatency(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .mem_rdata(mem_rdata),
    .output0(oa[0]), .output1(oa[1]), .output2(oa[2]), .output3(oa[3]),
    .output4(oa[4]), .output5(oa[5]), .output6(oa[6]), .output7(oa[7]),
    .output8(oa[8]), .output9(oa[9]), .output10(oa[10]), .output11(oa[11]),
    .output12(oa[12]), .output13(oa[13]), .output14(oa[14]), .output15(oa[15]),
    .busy(busy_a), .collision(coll_a));

  memory_rdata_demux #(.ParamNumPorts(16), .DataWidth(32), .ParamReadLatency(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .mem_rdata(mem_rdata),
    .output0(ob[0]), .output1(ob[1]), .output2(ob[2]), .output3(ob[3]),
    .output4(ob[4]), .output5(ob[5]), .output6(ob[6]), .output7(ob[7]),
    .output8(ob[8]), .output9(ob[9]), .output10(ob[10]), .output11(ob[11]),
    .output12(ob[12]), .output13(ob[13]), .output14(ob[14]), .output15(ob[15]),
    .busy(busy_b), .collision(coll_b));

  memory_rdata_demux #(.ParamNumPorts(4), .DataWidth(32), .ParamReadLatency(4)) dut_c (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .mem_rdata(mem_rdata),
    .output0(oc[0]), .output1(oc[1]), .output2(oc[2]), .output3(oc[3]),
    .output4(oc[4]), .output5(oc[5]), .output6(oc[6]), .output7(oc[7]),
    .output8(oc[8]), .output9(oc[9]), .output10(oc[10]), .output11(oc[11]),
    .output12(oc[12]), .output13(oc[13]), .output14(oc[14]), .output15(oc[15]),
    .busy(busy_c), .collision(coll_c));

  typedef struct {
    logic [15:0] req;
    logic [31:0] rdata;
    logic [15:0] exp_v;
    int unsigned port;
    logic [31:0] exp_d;
    logic        exp_busy;
    logic        exp_coll;
  } vec_t;

  vec_t tbl [14];

  function automatic logic [15:0] valids_of(input logic [32:0] o [16]);
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = o[i][32];
    return v;
  endfunction

  function automatic logic all_zero(input logic [32:0] o [16]);
    logic z;
    z = 1'b1;
    for (int i = 0; i < 16; i++) if (o[i] != '0) z = 1'b0;
    return z;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] bq_req [7];
    logic [31:0] bq_rd  [7];
    logic [15:0] bq_v   [7];
    logic        bq_bsy [7];
    logic [31:0] bq_d   [7];
    int unsigned bq_p   [7];

    tbl[0]  = '{16'h0004, 32'h0,        16'h0000, 2, 32'h0,        1'b1, 1'b0};
    tbl[1]  = '{16'h0000, 32'h0,        16'h0000, 2, 32'h0,        1'b1, 1'b0};
    tbl[2]  = '{16'h0000, 32'hDEADBEEF, 16'h0004, 2, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3]  = '{16'h0000, 32'h0,        16'h0000, 2, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[4]  = '{16'h0001, 32'h0,        16'h0000, 0, 32'h0,        1'b1, 1'b0};
    tbl[5]  = '{16'h0002, 32'h0,        16'h0000, 0, 32'h0,        1'b1, 1'b0};
    tbl[6]  = '{16'h0001, 32'h11111111, 16'h0001, 0, 32'h11111111, 1'b1, 1'b0};
    tbl[7]  = '{16'h0000, 32'h22222222, 16'h0002, 1, 32'h22222222, 1'b1, 1'b0};
    tbl[8]  = '{16'h0000, 32'h33333333, 16'h0001, 0, 32'h33333333, 1'b0, 1'b0};
    tbl[9]  = '{16'h0000, 32'h0,        16'h0000, 0, 32'h33333333, 1'b0, 1'b0};
    tbl[10] = '{16'h0030, 32'h0,        16'h0000, 4, 32'h0,        1'b1, 1'b1};
    tbl[11] = '{16'h0000, 32'h0,        16'h0000, 4, 32'h0,        1'b1, 1'b1};
    tbl[12] = '{16'h0000, 32'h55AA55AA, 16'h0010, 4, 32'h55AA55AA, 1'b0, 1'b1};
    tbl[13] = '{16'h0000, 32'h0,        16'h0000, 5, 32'h0,        1'b0, 1'b1};

    // Reset with a request asserted
    rst_n     = 1'b0;
    rd_req    = 16'h0001;
    mem_rdata = 32'hFFFFFFFF;
    step();
    step();
    chk("rst_zero_a", {63'd0, all_zero(oa)}, 64'd1);
    chk("rst_zero_b", {63'd0, all_zero(ob)}, 64'd1);
    chk("rst_zero_c", {63'd0, all_zero(oc)}, 64'd1);
    chk("rst_busy",   {61'd0, busy_a, busy_b, busy_c}, 64'd0);
    chk("rst_coll",   {61'd0, coll_a, coll_b, coll_c}, 64'd0);
    rst_n  = 1'b1;
    rd_req = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_nopulse", {16'd0, valids_of(oa), valids_of(ob), valids_of(oc)}, 64'd0);
    end

    // Table-driven: latency 2 instance
    for (int i = 0; i < 14; i++) begin
      rd_req    = tbl[i].req;
      mem_rdata = tbl[i].rdata;
      step();
      chk($sformatf("tbl%0d_valid", i), {48'd0, valids_of(oa)}, {48'd0, tbl[i].exp_v});
      chk($sformatf("tbl%0d_data", i), {32'd0, oa[tbl[i].port][31:0]}, {32'd0, tbl[i].exp_d});
      chk($sformatf("tbl%0d_busy", i), {63'd0, busy_a}, {63'd0, tbl[i].exp_busy});
      chk($sformatf("tbl%0d_coll", i), {63'd0, coll_a}, {63'd0, tbl[i].exp_coll});
    end

    do_reset();
    chk("coll_cleared", {63'd0, coll_a}, 64'd0);

    // Back-to-back on the latency 3 instance: ports 0,1,0
    bq_req = '{16'h0001, 16'h0002, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0};
    bq_rd  = '{32'h0, 32'h0, 32'h0, 32'hA1, 32'hB2, 32'hC3, 32'h0};
    bq_v   = '{16'h0, 16'h0, 16'h0, 16'h0001, 16'h0002, 16'h0001, 16'h0};
    bq_bsy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bq_p   = '{0, 0, 0, 0, 1, 0, 1};
    bq_d   = '{32'h0, 32'h0, 32'h0, 32'hA1, 32'hB2, 32'hC3, 32'hB2};
    for (int i = 0; i < 7; i++) begin
      rd_req    = bq_req[i];
      mem_rdata = bq_rd[i];
      step();
      chk($sformatf("b2b%0d_valid", i), {48'd0, valids_of(ob)}, {48'd0, bq_v[i]});
      chk($sformatf("b2b%0d_busy", i), {63'd0, busy_b}, {63'd0, bq_bsy[i]});
      chk($sformatf("b2b%0d_data", i), {32'd0, ob[bq_p[i]][31:0]}, {32'd0, bq_d[i]});
    end

    // Mid-flight reset on the latency 4 instance
    do_reset();
    rd_req = 16'h0008;
    step();
    chk("mid_busy_issue", {63'd0, busy_c}, 64'd1);
    rd_req = 16'h0000;
    step();
    rst_n = 1'b0;
    step();
    chk("mid_busy_rst", {63'd0, busy_c}, 64'd0);
    rst_n     = 1'b1;
    mem_rdata = 32'h12345678;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_no_pulse", {16'd0, valids_of(oc), 32'd0}, 64'd0);
      chk("mid_out3", {31'd0, oc[3]}, 64'd0);
      chk("mid_busy", {63'd0, busy_c}, 64'd0);
    end

    // Masking: 4-port instance ignores requester 8
    rd_req = 16'h0100;
    step();
    chk("mask_busy", {63'd0, busy_c}, 64'd0);
    rd_req = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mask_out8", {31'd0, oc[8]}, 64'd0);
      chk("mask_busy_hold", {63'd0, busy_c}, 64'd0);
      chk("mask_zero", {63'd0, all_zero(oc)}, 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_rdata_demux.md
Name: memory_rdata_demux

Overview:
- Return path for the memory-side request multiplexers: routes read data from a single fixed-latency memory read port back to the requester that issued each read.
- Tracks the issuing requester index through a tag pipeline matched to the memory read latency.
- Drives per-requester {valid, data} bundles in the same packed format the request muxes consume: bit DataWidth is valid, bits [DataWidth-1:0] are data.
- Sits between the memory read port and the HLS datapath consumers.

Parameters:
- ParamNumPorts, 1, number of requesters in use (1..16); output indices >= ParamNumPorts are tied to 0.
- DataWidth, 32, memory read data width.
- ParamReadLatency, 1, cycles from request sample to mem_rdata valid (1..4).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- rd_req  in  16  per-requester read-issue strobe, same cycle the address mux forwards that requester's address; bits >= ParamNumPorts ignored.
- mem_rdata  in  DataWidth  memory read data, valid exactly ParamReadLatency cycles after the issuing request.
- output0..output15  out  DataWidth+1 each  {valid, data} return bundle per requester.
- busy  out  1  one or more reads in flight.
- collision  out  1  sticky: more than one rd_req bit seen in one cycle.

Behaviour:
- Reset (rst_n=0 at a rising edge): all outputN = 0, busy = 0, collision = 0, tag pipeline cleared (all stages invalid).
- Issue: at each edge, if any masked rd_req bit is set, push {valid=1, idx = lowest set index} into stage 0 of the tag pipeline. Otherwise push an invalid tag.
- Tag pipeline: ParamReadLatency stages; every stage shifts each cycle (no stall). A tag sampled at edge t reaches the last stage at edge t+ParamReadLatency-1. mem_rdata is sampled in the cycle that tag is in the last stage.
- Return: when the last stage is valid with index k, at the next edge:
  - output k gets valid = 1 and data = mem_rdata.
  - Every other output gets valid = 0 and keeps its previous data bits.
- Total latency: request edge t → outputk valid visible after edge t+ParamReadLatency.
- Valid is a 1-cycle pulse. Data bits hold until the next return to the same port; consumers may read them late.
- Back-to-back: one request per cycle is sustained indefinitely. Returns for the same or different ports arrive in consecutive cycles, in issue order.
- Collision: multi-hot rd_req sets collision (sticky until reset). Only the lowest index is tracked; the other requests get no return.
- busy = OR of all tag stage valids. It is combinational from registers and does not include the stage being loaded this edge.
- Reset mid-operation: in-flight tags are dropped. mem_rdata arriving after reset is ignored. No output valid pulses after reset until a new request completes.
- Unused ports (index >= ParamNumPorts) are constant 0 and never pulse.

Decomposition:
- Shared package memory_pkg:
  - MAX_PORTS = 16
  - typedef port_idx_t (4 bits)
  - typedef rtag_t struct {valid, idx}
  - function lowest_set_index for a 16-bit vector
- Sub-module rtag_pipe: parameterised-depth shift register of rtag_t with synchronous active-low clear. Instantiated once.

Test Plan:
- Reset: assert rst_n=0 with rd_req=16'h0001 → all outputs 0, busy=0, collision=0; no pulse after release.
- Latency: L=2, rd_req=16'h0004 at edge 10, mem_rdata=32'hDEADBEEF during cycle 11–12 → output2 = {1,32'hDEADBEEF} after edge 12 only; next cycle valid=0 and data held.
- Back-to-back: L=3, ports 0,1,0 on consecutive edges with rdata A1, B2, C3 → output0 pulses A1, output1 pulses B2, output0 pulses C3 on consecutive cycles; busy high throughout, low after the last return.
- Collision: rd_req=16'h0030 → only output4 returns; collision=1 and stays 1 until reset.
- Mid-flight reset: L=4, issue to port 3, pulse rst_n low 2 edges later → no output3 pulse; busy=0.
- Masking: ParamNumPorts=4, rd_req=16'h0100 → no tag pushed, busy stays 0, output8 stays 0.
